// File: rtl/slt_exec_stage.sv
// Registered execute stage for SLT/SLTU/SLTI/SLTIU with a one-entry skid buffer.
// Optional macro SLT_EXEC_STATS_EN adds the stat_true_cnt delivered-true counter.
module slt_exec_stage #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 6,
    parameter int RD_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_rs,
    input  logic [DATA_W-1:0] in_rt,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd
`ifdef SLT_EXEC_STATS_EN
    ,
    output logic [15:0]       stat_true_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_result_r;
    logic [RD_W-1:0]   out_rd_r;
    logic [DATA_W-1:0] skid_result_r;
    logic [RD_W-1:0]   skid_rd_r;
    logic              accept_s;
    logic              load_in_out_s;
    logic              load_skid_out_s;
    logic              load_skid_s;
    logic [DATA_W-1:0] new_result_s;

    // Immediate forms sign-extend even for SLTIU; only the compare flavour differs.
    function automatic logic slt_f(input logic [1:0] op, input logic [DATA_W-1:0] rs,
                                   input logic [DATA_W-1:0] rt, input logic [IMM_W-1:0] imm);
        logic [DATA_W-1:0] b;
        logic              lt;
        b = op[1] ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : rt;
        if (op[0]) begin
            lt = (rs < b);
        end else begin
            lt = ($signed(rs) < $signed(b));
        end
        return lt;
    endfunction

    assign accept_s     = in_valid & in_ready_r;
    assign new_result_s = {{(DATA_W-1){1'b0}}, slt_f(in_op, in_rs, in_rt, in_imm)};

    // Occupancy next-state and datapath load selects
    always_comb begin
        state_nxt_s     = state_r;
        load_in_out_s   = 1'b0;
        load_skid_out_s = 1'b0;
        load_skid_s     = 1'b0;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s   = ST_ONE;
                        load_in_out_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && out_ready) begin
                        state_nxt_s   = ST_ONE;
                        load_in_out_s = 1'b1;
                    end else if (accept_s) begin
                        state_nxt_s = ST_FULL;
                        load_skid_s = 1'b1;
                    end else if (out_ready) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_nxt_s     = ST_ONE;
                        load_skid_out_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State, handshake flags and payload registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_EMPTY;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_result_r  <= {DATA_W{1'b0}};
            out_rd_r      <= {RD_W{1'b0}};
            skid_result_r <= {DATA_W{1'b0}};
            skid_rd_r     <= {RD_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_FULL);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            if (load_in_out_s) begin
                out_result_r <= new_result_s;
                out_rd_r     <= in_rd;
            end else if (load_skid_out_s) begin
                out_result_r <= skid_result_r;
                out_rd_r     <= skid_rd_r;
            end
            if (load_skid_s) begin
                skid_result_r <= new_result_s;
                skid_rd_r     <= in_rd;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_rd     = out_rd_r;

`ifdef SLT_EXEC_STATS_EN
    logic [15:0] stat_cnt_r;

    // Saturating count of true results accepted by writeback; flush does not clear it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_cnt_r <= 16'h0000;
        end else if (out_valid_r && out_ready && !flush && out_result_r[0] &&
                     (stat_cnt_r != 16'hFFFF)) begin
            stat_cnt_r <= stat_cnt_r + 16'd1;
        end
    end

    assign stat_true_cnt = stat_cnt_r;
`endif

endmodule
